uart_rx_mmio: RTL

Memory-mapped UART receiver: the console-input counterpart to the simulated UART output at 0x10000000. It deserialises 8N1 frames from a serial `rx` line into a byte FIFO and exposes data and status registers to the CPU load path. It sits beside data RAM on the MEM stage. Address decode and read data are combinational, like the RAM.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_mmio.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: MMIO addresses, status bit layout, receiver FSM encoding.
package uart_pkg;

    localparam logic [31:0] UART_TX_ADDR      = 32'h1000_0000;
    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1000_0004;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1000_0008;

    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_FULL       = 1;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_FRAME_ERR  = 3;
    localparam int STAT_PARITY_ERR = 4;
    localparam int STAT_COUNT_LSB  = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Even-parity bit for a data byte: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: synchronous push/pop, registered count, combinational head.
// A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
module uart_rx_fifo #(
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [7:0]       push_data_i,
    input  logic             pop_i,
    output logic [7:0]       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop_s;
    logic             do_push_s;

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with byte FIFO, data/status registers and IRQ.
// Optional even parity bit after bit 7 when UART_RX_PARITY_EN is defined.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] DATA_ADDR    = UART_RX_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR    = UART_RX_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [31:0] addr,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rx_irq
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       warm_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             rx_irq_q;
    logic             rx_s, fall_s, sample_s;
    logic             push_s, frame_set_s, overrun_set_s;
    logic             pop_s, stat_clr_s;
    logic             parity_err_s;
    logic [7:0]       head_s;
    logic [CW-1:0]    count_s;
    logic [3:0]       count_field_s;
    logic             full_s, empty_s;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
    logic             parity_set_s;
`endif

    assign rx_s          = sync2_q;
    // The warm-up stage keeps the edge detector disarmed until the synchroniser holds real line data.
    assign fall_s        = prev_q && !sync2_q;
    assign pop_s         = re && (addr == DATA_ADDR) && !empty_s;
    assign stat_clr_s    = re && (addr == STAT_ADDR);
    assign overrun_set_s = push_s && full_s && !pop_s;
    assign rx_irq        = rx_irq_q;

    // Two-flop synchroniser, falling-edge history and post-reset warm-up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b0;
            warm_q  <= 2'b00;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= warm_q[1] ? sync2_q : 1'b0;
            warm_q  <= {warm_q[0], 1'b1};
        end
    end

    // Receiver state, bit timing, shift register, sticky flags and IRQ registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_irq_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_irq_q    <= !empty_s;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Sample strobe: half a bit into the start bit, then every full bit period.
    always_comb begin
        case (state_q)
            RX_START:                    sample_s = (cnt_q == HALF_LAST);
            RX_DATA, RX_PARITY, RX_STOP: sample_s = (cnt_q == BIT_LAST);
            default:                     sample_s = 1'b0;
        endcase
    end

    // Next-state logic of the frame FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: begin
                if (fall_s) state_d = RX_START;
                else        state_d = RX_IDLE;
            end
            RX_START: begin
                if (sample_s) state_d = rx_s ? RX_IDLE : RX_DATA;
                else          state_d = RX_START;
            end
            RX_DATA: begin
                if (sample_s && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = RX_PARITY;
`else
                    state_d = RX_STOP;
`endif
                end else begin
                    state_d = RX_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (sample_s) state_d = RX_STOP;
                else          state_d = RX_PARITY;
            end
`endif
            RX_STOP: begin
                if (sample_s) state_d = RX_IDLE;
                else          state_d = RX_STOP;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // FSM outputs: bit timer, data capture, push request and error strobes.
    always_comb begin
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_set_s = 1'b0;
`endif
        if ((state_q == RX_IDLE) || sample_s) cnt_d = {CNT_W{1'b0}};
        else                                  cnt_d = cnt_q + CNT_W'(1);
        case (state_q)
            RX_IDLE: begin
                bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            RX_DATA: begin
                if (sample_s) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end else begin
                    shift_d = shift_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (sample_s) begin
                    par_bad_d    = (rx_s != even_parity(shift_q));
                    parity_set_s = (rx_s != even_parity(shift_q));
                end else begin
                    par_bad_d = par_bad_q;
                end
            end
`endif
            RX_STOP: begin
                if (sample_s && rx_s) begin
`ifdef UART_RX_PARITY_EN
                    push_s = !par_bad_q;
`else
                    push_s = 1'b1;
`endif
                end else if (sample_s) begin
                    frame_set_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Sticky flags: a status read clears them, but a same-cycle set wins.
    always_comb begin
        overrun_d   = (stat_clr_s ? 1'b0 : overrun_q) | overrun_set_s;
        frame_err_d = (stat_clr_s ? 1'b0 : frame_err_q) | frame_set_s;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (stat_clr_s ? 1'b0 : parity_err_q) | parity_set_s;
        parity_err_s = parity_err_q;
`else
        parity_err_s = 1'b0;
`endif
    end

    // Zero-extend or clip the FIFO count into the 4-bit status field.
    always_comb begin
        count_field_s = 4'd0;
        for (int i = 0; (i < CW) && (i < 4); i++) count_field_s[i] = count_s[i];
    end

    // Combinational register read decode.
    always_comb begin
        rdata = 32'd0;
        if (addr == DATA_ADDR) begin
            if (!empty_s) rdata = {24'd0, head_s};
            else          rdata = 32'd0;
        end else if (addr == STAT_ADDR) begin
            rdata[STAT_NOT_EMPTY]                 = !empty_s;
            rdata[STAT_FULL]                      = full_s;
            rdata[STAT_OVERRUN]                   = overrun_q;
            rdata[STAT_FRAME_ERR]                 = frame_err_q;
            rdata[STAT_PARITY_ERR]                = parity_err_s;
            rdata[STAT_COUNT_LSB+3:STAT_COUNT_LSB] = count_field_s;
        end else begin
            rdata = 32'd0;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_s),
        .push_data_i(shift_q),
        .pop_i      (pop_s),
        .head_o     (head_s),
        .count_o    (count_s),
        .full_o     (full_s),
        .empty_o    (empty_s)
    );

endmodule
